// File: rtl/systolic_pkg.sv
// Shared types, default constants and helpers for the systolic frame player.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } player_state_t;

    localparam int SYS_W    = 16;
    localparam int SYS_N    = 8;
    localparam int SYS_RATE = 30;

    function automatic logic [31:0] sext32(input logic [SYS_W-1:0] v);
        return {{(32-SYS_W){v[SYS_W-1]}}, v};
    endfunction

endpackage

// File: rtl/sample_result_fifo.sv
// Result FIFO: push/full write side, valid/ready read side, registered storage
// so a push is visible on the read side one cycle later (no bypass).
module sample_result_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 35
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    output logic          o_full,
    output logic          o_pop_valid,
    input  logic          i_pop_ready,
    output logic [DW-1:0] o_pop_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the head is being taken.
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_pop_valid = (r_count != '0);
    assign w_pop       = o_pop_valid && i_pop_ready;
    assign w_push      = i_push && (!o_full || w_pop);
    assign o_pop_data  = o_pop_valid ? r_mem[r_rd] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_push_data;
    end

endmodule

// File: rtl/systolic_frame_player.sv
// Plays a stored frame into the systolic array at a fixed sample rate for a
// number of passes and streams indexed, sign-extended array outputs.
module systolic_frame_player
    import systolic_pkg::*;
#(
    parameter int N      = SYS_N,
    parameter int W      = SYS_W,
    parameter int RATE   = SYS_RATE,
    parameter int PASSES = 3,
    parameter int LAT    = 2,
    parameter int DEPTH  = 4
) (
    input  logic                 clk30x,
    input  logic                 rst,
    input  logic                 ld_we,
    input  logic [$clog2(N)-1:0] ld_addr,
    input  logic [W-1:0]         ld_data,
    input  logic                 start,
    output logic [W-1:0]         xin,
    input  logic [W-1:0]         yout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [$clog2(N)-1:0] res_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output player_state_t        o_state
);

    localparam int AW     = $clog2(N);
    localparam int TW     = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int K_END  = PASSES * N;
    localparam int K_LAST = K_END + LAT - 1;
    localparam int KW     = $clog2(K_END + LAT + 1);
    localparam int DW     = 32 + AW;

    logic [W-1:0]  r_mem [N];
    player_state_t r_state;
    logic [TW-1:0] r_tick;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_xin;
    logic          r_done;
    logic          r_overflow;

    logic          w_edge;
    logic          w_last;
    logic          w_capture;
    logic          w_full;
    logic          w_pop;
    logic          w_drop;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_ext;
    logic [DW-1:0] w_fifo_out;

    // r_k is the index of the next sample edge; edge 0 is the start edge itself.
    assign w_edge    = (r_state != IDLE) && (r_tick == TW'(RATE - 1));
    assign w_last    = (r_k == KW'(K_LAST));
    assign w_capture = w_edge && (r_k >= KW'(LAT));
    assign w_idx     = r_k[AW-1:0] - AW'(LAT);
    assign w_pop     = res_valid && res_ready;
    assign w_drop    = w_capture && w_full && !w_pop;

    if (W == SYS_W) begin : g_sext_pkg
        assign w_ext = sext32(yout);
    end else begin : g_sext_gen
        assign w_ext = {{(32-W){yout[W-1]}}, yout};
    end

    always_ff @(posedge clk30x) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_k        <= '0;
            r_xin      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_tick     <= '0;
                        r_k        <= KW'(1);
                        r_xin      <= r_mem[0];
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    if (w_edge) begin
                        r_tick <= '0;
                        r_k    <= r_k + 1'b1;
                        if (w_last) begin
                            r_state <= IDLE;
                            r_xin   <= '0;
                            r_done  <= 1'b1;
                            r_k     <= '0;
                        end else begin
                            if (r_k == KW'(K_END)) r_state <= DRAIN;
                            r_xin <= (r_state == RUN) ? r_mem[r_k[AW-1:0]] : '0;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame memory is deliberately not reset; it only accepts writes in IDLE.
    always_ff @(posedge clk30x) begin
        if (rst && ld_we && (r_state == IDLE)) r_mem[ld_addr] <= ld_data;
    end

    // Result stream: a beat transfers on res_valid && res_ready; res_valid is
    // registered-only and the head is held stable while res_ready is low.
    sample_result_fifo #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_fifo (
        .i_clk      (clk30x),
        .i_rst      (rst),
        .i_push     (w_capture),
        .i_push_data({w_idx, w_ext}),
        .o_full     (w_full),
        .o_pop_valid(res_valid),
        .i_pop_ready(res_ready),
        .o_pop_data (w_fifo_out)
    );

    assign xin      = r_xin;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign o_state  = r_state;
    assign res_data = w_fifo_out[31:0];
    assign res_idx  = w_fifo_out[DW-1:32];

endmodule

// File: tb/tb_systolic_frame_player.sv
// Bench for systolic_frame_player: cycle-level reference model with an expected
// result queue, an array model driving yout, and directed/randomised runs.
module tb_systolic_frame_player;
    import systolic_pkg::*;

    localparam int N      = 8;
    localparam int W      = 16;
    localparam int RATE   = 30;
    localparam int PASSES = 3;
    localparam int LAT    = 2;
    localparam int DEPTH  = 4;
    localparam int PN     = PASSES * N;
    localparam int NV     = 6;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
    } res_t;

    typedef struct {
        logic [15:0] yin;
        logic [31:0] exp_data;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          ld_we;
    logic [2:0]    ld_addr;
    logic [W-1:0]  ld_data;
    logic          start;
    logic [W-1:0]  xin;
    logic [W-1:0]  yout;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic [2:0]    res_idx;
    logic          busy;
    logic          done;
    logic          overflow;
    player_state_t o_state;

    systolic_frame_player #(
        .N(N), .W(W), .RATE(RATE), .PASSES(PASSES), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk30x   (clk),
        .rst      (rst),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .xin      (xin),
        .yout     (yout),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_idx  (res_idx),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .o_state  (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        int s;
        s = $signed(v);
        return s;
    endfunction

    // Reference model state: what the outputs must show after the next edge.
    bit          mon_en = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_over = 1'b0;
    logic [15:0] m_xin  = '0;
    int          m_n    = 0;
    int          m_k    = 0;
    logic [15:0] m_mem [N];
    res_t        exp_q [$];
    bit          arr_edge  = 1'b0;
    bit          arr_start = 1'b0;
    int          ymode     = 0;
    int          arr_c     = 0;
    logic [15:0] hist  [$];
    res_t        got_q [$];
    logic [15:0] frame [N];
    vec_t        tbl   [NV];

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("overflow", 32'(overflow), 32'(m_over));
            check("xin", 32'(xin), 32'(m_xin));
            check("res_valid", 32'(res_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("res_idx", 32'(res_idx), 32'(exp_q[0].idx));
                check("res_data", res_data, exp_q[0].data);
            end
            arr_edge  = 1'b0;
            arr_start = 1'b0;
            if (!rst) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_over = 1'b0;
                m_xin  = '0;
                exp_q.delete();
            end else begin
                m_done = 1'b0;
                if (exp_q.size() > 0 && res_ready) void'(exp_q.pop_front());
                if (!m_busy) begin
                    if (ld_we) m_mem[ld_addr] = ld_data;
                    if (start) begin
                        m_busy    = 1'b1;
                        m_n       = 0;
                        m_xin     = m_mem[0];
                        m_over    = 1'b0;
                        arr_edge  = 1'b1;
                        arr_start = 1'b1;
                    end
                end else begin
                    m_n++;
                    if (m_n % RATE == 0) begin
                        m_k      = m_n / RATE;
                        arr_edge = 1'b1;
                        if (m_k >= LAT) begin
                            if (exp_q.size() < DEPTH)
                                exp_q.push_back('{idx: 3'((m_k - LAT) % N), data: sx(yout)});
                            else
                                m_over = 1'b1;
                        end
                        if (m_k == PN + LAT - 1) begin
                            m_xin  = '0;
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end else if (m_k <= PN) begin
                            m_xin = m_mem[m_k % N];
                        end else begin
                            m_xin = '0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst && res_valid && res_ready)
            got_q.push_back('{idx: res_idx, data: res_data});
    end

    // Array model: after each sample edge, present the value for the next capture.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (arr_edge) begin
                if (arr_start) hist.delete();
                hist.push_back(xin);
                arr_c = hist.size() - LAT;
                if (ymode == 2)      yout = 16'($urandom);
                else if (arr_c < 0)  yout = '0;
                else if (ymode == 1) yout = tbl[arr_c % NV].yin;
                else                 yout = hist[arr_c];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_frame();
        for (int i = 0; i < N; i++) begin
            ld_we   = 1'b1;
            ld_addr = 3'(i);
            ld_data = frame[i];
            tick(1);
        end
        ld_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++) tick(1);
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        int ov_at;

        tbl[0] = '{16'h8001, 32'hFFFF8001};
        tbl[1] = '{16'h7FFF, 32'h00007FFF};
        tbl[2] = '{16'h0000, 32'h00000000};
        tbl[3] = '{16'hFFFF, 32'hFFFFFFFF};
        tbl[4] = '{16'h8000, 32'hFFFF8000};
        tbl[5] = '{16'h1234, 32'h00001234};
        for (int i = 0; i < N; i++) m_mem[i] = '0;

        rst = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; yout = '0; res_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with random inputs, including start.
        for (int i = 0; i < 3; i++) begin
            ld_we     = 1'($urandom_range(0, 1));
            ld_addr   = 3'($urandom_range(0, N - 1));
            ld_data   = 16'($urandom);
            yout      = 16'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            start     = 1'b1;
            tick(1);
        end
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_xin", 32'(xin), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_idx", 32'(res_idx), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state", 32'(o_state), 32'(IDLE));
        rst = 1'b1; start = 1'b0; ld_we = 1'b0; yout = '0;
        tick(1);
        check("start_in_reset", 32'(busy), 32'd0);

        // Nominal run.
        for (int i = 0; i < N; i++) frame[i] = 16'(i + 1);
        load_frame();
        res_ready = 1'b1;
        ymode = 0;
        got_q.delete();
        start_run();
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int c = 1; c <= 760; c++) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = c; end
            tick(1);
        end
        check("nom_busy_cycles", 32'(busy_cnt), 32'd750);
        check("nom_done_count", 32'(done_cnt), 32'd1);
        check("nom_done_cycle", 32'(done_at), 32'd751);
        check("nom_result_count", 32'(got_q.size()), 32'(PN));
        for (int c = 0; c < PN && c < got_q.size(); c++) begin
            check("nom_idx", 32'(got_q[c].idx), 32'(c % N));
            check("nom_data", got_q[c].data, sx(frame[c % N]));
        end

        // Sign extension, table-driven yout per capture.
        ymode = 1;
        got_q.delete();
        start_run();
        wait_idle(800);
        tick(5);
        check("sext_count", 32'(got_q.size()), 32'(PN));
        for (int c = 0; c < PN && c < got_q.size(); c++)
            check("sext_tbl", got_q[c].data, tbl[c % NV].exp_data);

        // Backpressure over a whole run.
        ymode = 0;
        res_ready = 1'b0;
        got_q.delete();
        start_run();
        ov_at = 0;
        for (int c = 1; c <= 760; c++) begin
            if (overflow && ov_at == 0) ov_at = c;
            tick(1);
        end
        check("bp_overflow_cycle", 32'(ov_at), 32'd181);
        check("bp_valid_held", 32'(res_valid), 32'd1);
        check("bp_idle", 32'(busy), 32'd0);
        res_ready = 1'b1;
        tick(10);
        check("bp_transfers", 32'(got_q.size()), 32'(DEPTH));
        for (int c = 0; c < DEPTH && c < got_q.size(); c++) begin
            check("bp_idx", 32'(got_q[c].idx), 32'(c));
            check("bp_data", got_q[c].data, sx(frame[c]));
        end
        check("bp_empty", 32'(res_valid), 32'd0);

        // Reset in the middle of a run, then a clean run.
        got_q.delete();
        start_run();
        tick(300);
        rst = 1'b0;
        tick(1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_xin", 32'(xin), 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) done_cnt++;
            tick(1);
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        got_q.delete();
        start_run();
        wait_idle(800);
        tick(5);
        check("rerun_count", 32'(got_q.size()), 32'(PN));
        for (int c = 0; c < PN && c < got_q.size(); c++)
            check("rerun_idx", 32'(got_q[c].idx), 32'(c % N));

        // start and ld_we pulsed while busy are ignored.
        got_q.delete();
        start_run();
        busy_cnt = 0;
        for (int c = 1; c <= 760; c++) begin
            if (c == 100) begin
                start = 1'b1; ld_we = 1'b1; ld_addr = '0; ld_data = 16'hBEEF;
            end else begin
                start = 1'b0; ld_we = 1'b0;
            end
            if (busy) busy_cnt++;
            tick(1);
        end
        check("ign_busy_cycles", 32'(busy_cnt), 32'd750);
        got_q.delete();
        start_run();
        wait_idle(800);
        tick(5);
        check("ign_count", 32'(got_q.size()), 32'(PN));
        check("ign_mem0", got_q.size() > 0 ? got_q[0].data : 32'hDEAD, 32'h00000001);

        // Randomised runs: random frames, random ready, noise while busy.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
            load_frame();
            ymode = (r == 1) ? 2 : 0;
            res_ready = 1'b1;
            got_q.delete();
            start_run();
            for (int c = 0; c < 800 && busy; c++) begin
                res_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 49) == 0);
                ld_we     = ($urandom_range(0, 49) == 0);
                ld_addr   = 3'($urandom_range(0, N - 1));
                ld_data   = 16'($urandom);
                tick(1);
            end
            start = 1'b0; ld_we = 1'b0;
            check("rand_idle", 32'(busy), 32'd0);
            res_ready = 1'b1;
            tick(10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_frame_player.md
# systolic_frame_player

Synthesizable stimulus/capture end for the systolic Chebyshev filter array. Plays a stored frame of N samples into the array's `xin` at a fixed sample rate for a configurable number of passes, samples the array's `yout` on each sample edge, and delivers indexed, sign-extended results through a valid/ready stream backed by a small FIFO. Sits beside `systolic_wrapper` and moves frame feed and result collection into hardware.

## Interface
- `N`, 8: frame length in samples; power of two, ≥ 2.
- `W`, 16: sample width, two's complement.
- `RATE`, 30: `clk30x` cycles per sample period; ≥ 2.
- `PASSES`, 3: frame repetitions per run; ≥ 1.
- `LAT`, 2: array latency in sample periods; 1 ≤ LAT < N.
- `DEPTH`, 4: result FIFO depth; power of two.
- `clk30x` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low (`rst`=0 resets on the next edge).
- `ld_we` in 1: frame memory write strobe, honoured only in IDLE.
- `ld_addr` in log2(N): frame memory write address.
- `ld_data` in W: frame memory write data.
- `start` in 1: begins a run when sampled high in IDLE.
- `xin` out W: sample to the array.
- `yout` in W: array output.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 32: `yout` sign-extended to 32 bits.
- `res_idx` out log2(N): frame index of the result.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at end of run.
- `overflow` out 1: sticky; result dropped because the FIFO was full.

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: `ld_we` writes `ld_data` to `mem[ld_addr]`. `start`=1 → RUN and clears `overflow`.
- Sample edges E_k, k = 0,1,2…: E_0 is the IDLE→RUN edge; E_k = E_0 + k·RATE. A tick counter 0..RATE-1 times them.
- At E_k in RUN: `xin` ← `mem[k mod N]`. At E_k in DRAIN: `xin` ← 0.
- Capture: at E_k with k ≥ LAT, push {sign-extended `yout` as seen before the edge, idx = (k−LAT) mod N} into the FIFO.
- RUN → DRAIN at E_{PASSES·N}. DRAIN → IDLE at E_{PASSES·N+LAT−1}. That edge also captures, sets `xin` to 0, and raises `done` for the following cycle.
- Exactly PASSES·N captures per run, with idx 0..N−1 repeating.
- FIFO full at a capture: the result is dropped and `overflow` set. A pop in the same cycle frees a slot first, so the push is accepted.
- `start` while busy: ignored. `ld_we` while busy: ignored; memory is unchanged.
- Memory contents are undefined until written and are not cleared by reset.

## Timing
- Reset values: `xin`=0, `res_valid`=0, `res_data`=0, `res_idx`=0, `busy`=0, `done`=0, `overflow`=0. The FIFO is emptied and the tick counter is 0.
- Reset mid-run: at the next edge the block is in IDLE with all reset values, FIFO contents discarded and no `done`.
- `start` sampled at edge E_0: `busy`=1 and `xin`=`mem[0]` in the cycle after E_0.
- A capture pushed at edge E appears on `res_*` the cycle after E if the FIFO was empty: one-cycle FIFO latency, no bypass.
- Handshake: transfer on `res_valid`&&`res_ready`. `res_data`/`res_idx` stay stable while `res_valid`&&!`res_ready`. `res_valid` does not depend combinationally on `res_ready`.
- `busy` falls and `done` pulses in the same cycle, the one after the last DRAIN edge. `start` is accepted again from that cycle.

## Structure
- Package `systolic_pkg` holds:
  - state enum `player_state_t` {IDLE, RUN, DRAIN};
  - default constants `SYS_W`=16, `SYS_N`=8, `SYS_RATE`=30;
  - function `sext32(W-bit)`.
- Sub-module `sample_result_fifo`: synchronous FIFO with parameters DEPTH and width 32+log2(N), a push/full port and a valid/ready pop side.
- Frame memory is an inferred register array in the top module.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → all outputs at reset values; `start` while `rst`=0 has no effect.
- Nominal run:
  - Setup: defaults; load mem = 0x0001..0x0008; model `yout` = `xin` delayed 2 sample periods; `res_ready`=1; `start` at edge t.
  - Results: 24 results with idx 0..7 ×3 and `res_data` = mem[idx].
  - Timing: `busy` high over cycles t+1..t+750; `done` one cycle at t+751.
- Sign extension: `yout`=16'h8001 at a capture edge → `res_data`=32'hFFFF8001; `yout`=16'h7FFF → 32'h00007FFF.
- Backpressure:
  - `res_ready`=0 for the whole run → first 4 captures (idx 0..3) held in order and `overflow`=1 from the 5th capture.
  - Then `res_ready`=1 → exactly 4 transfers, after which `res_valid`=0.
- Reset mid-run: `rst`=0 after E_10 → next cycle `busy`=0, `xin`=0, `res_valid`=0, no `done`; a new `start` gives a full 24-result run from idx 0.
- Ignored inputs while busy: pulse `start` and `ld_we` (addr 0, data 0xBEEF) mid-run → run length unchanged; mem[0] still 0x0001 on the next run.
